icon_fetch_ctrl: RTL and testbench
==================================

Name: icon_fetch_ctrl

Overview:
- Controller that sequences sprite-ROM reads for the bot icon on the VGA display. Eight orientations share one 2048x2 sprite ROM instead of one ROM per orientation.
- Latches bot location and orientation once per frame, so the icon never tears mid-frame.
- Computes the ROM address from pixel position relative to the icon origin, with no running address counter.
- Delivers a registered 2-bit icon colour code to the colorizer with fixed pipeline latency.

Parameters:
- ICON_W, 16, icon width in pixels (power of 2).
- ICON_H, 16, icon height in pixels (power of 2).
- Y_SCALE, 6, screen rows per LocY unit.
- X_SHIFT, 3, column = LocX << X_SHIFT.
- ROM_AW, 11, sprite ROM address width = 3 + log2(ICON_H) + log2(ICON_W).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-clock pulse at start of vertical blanking.
- loc_valid  in  1  LocX/LocY/BotInfo carry a new update this clock.
- LocX  in  8  bot X location.
- LocY  in  8  bot Y location.
- BotInfo  in  8  bot info; [2:0] = orientation.
- icon_en  in  1  master enable; 0 forces transparent output.
- pix_tick  in  1  pixel_row/pixel_column are valid this clock.
- pixel_row  in  10  current pixel row.
- pixel_column  in  10  current pixel column.
- rom_addr  out  ROM_AW  sprite ROM address (registered).
- rom_data  in  2  sprite ROM data, 1-clock registered read.
- icon  out  2  icon colour code; 00 = transparent.
- icon_valid  out  1  icon corresponds to a pix_tick presented 3 clocks earlier.
- busy  out  1  a location is displayed (state SHOW).

Behaviour:
- Reset (reset=0, async): state=IDLE; rom_addr=0, icon=00, icon_valid=0, busy=0; shadow and active registers cleared; pipeline hit/valid flags cleared.
  - Reset asserted mid-line drops any in-flight pixel: icon=00 on the first clock after release.
- Shadow regs: on loc_valid, capture LocX, LocY, BotInfo[2:0] and set pend=1. A later loc_valid before frame_start overwrites (last wins).
- Active regs: on frame_start with pend=1, copy shadow to active and clear pend.
  - loc_valid and frame_start in the same clock: the incoming values go directly to active and pend stays 0.
- FSM:
  - IDLE -> ARMED on loc_valid.
  - ARMED -> SHOW on frame_start (activation).
  - SHOW -> SHOW on further activations.
  - Any state -> IDLE on icon_en=0 sampled at frame_start; the icon is blanked immediately whenever icon_en=0.
  - Output is non-transparent only in SHOW.
- Origin: oy = LocY*Y_SCALE and ox = LocX<<X_SHIFT, both computed in 11 bits. No wrap; an icon partly or fully off-screen is clipped naturally.
- Hit (stage 0, when pix_tick=1): pixel_row in [oy, oy+ICON_H-1] and pixel_column in [ox, ox+ICON_W-1], compared at 11-bit width.
- Address: rom_addr <= {orient, (row-oy)[3:0], (col-ox)[3:0]}, registered at stage 1. When there is no hit, rom_addr holds its value.
- Pipeline:
  - Stage 1: rom_addr register and hit_d1.
  - Stage 2: ROM output and hit_d2.
  - Stage 3: icon <= (hit_d2 & SHOW & icon_en) ? rom_data : 00; icon_valid <= tick_d2.
  - Latency: exactly 3 clocks from pix_tick to icon.
- Pipeline behaviour:
  - The pipeline advances every clock.
  - Gaps in pix_tick produce icon_valid=0 with icon=00.
  - Back-to-back ticks produce back-to-back outputs.
- Orientation codes: N=000, NE=001, E=010, SE=011, S=100, SW=101, W=110, NW=111. They map directly to ROM bank = orient*256.

Decomposition:
- Package icon_pkg: orientation enum (the 8 codes above), FSM state enum {IDLE, ARMED, SHOW}, ICON_W/ICON_H/Y_SCALE/X_SHIFT constants.
- Sub-module icon_sprite_rom: 2048x2 single-port block ROM wrapper, 1-clock read, 8 orientation images concatenated.

Test Plan:
- Reset, then loc_valid with LocX=10, LocY=20, BotInfo=0x02 (E), then frame_start; scan row 120 cols 80..95 -> rom_addr 0x200..0x20F; icon equals ROM E-bank row 0 with 3-clock latency; busy=1.
- Same location; pixel (135,95) -> rom_addr 0x2FF. Pixels (136,95) and (120,96) -> icon=00.
- loc_valid LocX=10/BotInfo=0x04 mid-frame, then a second loc_valid with BotInfo=0x07 before frame_start -> current frame keeps E; next frame uses NW (rom_addr base 0x700).
- loc_valid and frame_start in the same clock with LocY=255, LocX=0 -> oy=1530, no hit for any row 0..479, icon=00 for all valid pixels, no wrap hits at row 506.
- pix_tick pattern 1,0,1,1 inside the icon -> icon_valid 1,0,1,1 delayed by 3 clocks; icon=00 where icon_valid=0.
- In SHOW, assert reset=0 for 1 clock mid-scan -> icon=00, busy=0, state IDLE; the icon does not reappear until a new loc_valid plus frame_start.

Source files
------------

// File: rtl/icon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icon_pkg : shared constants, orientation/state encodings and sprite  |
// |            image generator for the bot icon fetch path.  Rev 1.0     |
// +----------------------------------------------------------------------+
package icon_pkg;

    localparam int ICON_W  = 16;
    localparam int ICON_H  = 16;
    localparam int Y_SCALE = 6;
    localparam int X_SHIFT = 3;
    localparam int ROM_AW  = 11;

    typedef enum logic [2:0] {
        OR_N  = 3'b000,
        OR_NE = 3'b001,
        OR_E  = 3'b010,
        OR_SE = 3'b011,
        OR_S  = 3'b100,
        OR_SW = 3'b101,
        OR_W  = 3'b110,
        OR_NW = 3'b111
    } orient_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    // Sprite image: XOR fold of the address in 2-bit groups, one image per bank.
    function automatic logic [1:0] sprite_pixel(input logic [ROM_AW-1:0] addr);
        logic [1:0] acc;
        acc = 2'b00;
        for (int i = 0; i < ROM_AW; i += 2) begin
            acc = acc ^ 2'(addr >> i);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icon_sprite_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icon_sprite_rom : 2048x2 sprite ROM, eight orientation images        |
// |                   concatenated, registered 1-clock read.  Rev 1.0    |
// +----------------------------------------------------------------------+
module icon_sprite_rom
    import icon_pkg::*;
(
    input  logic              clock,
    input  logic [ROM_AW-1:0] addr,
    output logic [1:0]        data
);

    logic [1:0] data_d;
    logic [1:0] data_q;

    always_comb begin
        data_d = sprite_pixel(addr);
    end

    // Block-ROM output register carries no reset.
    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/icon_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icon_fetch_ctrl : frame-latched bot location, sprite ROM addressing  |
// |                   and 3-clock icon colour pipeline.  Rev 1.0         |
// +----------------------------------------------------------------------+
module icon_fetch_ctrl #(
    parameter int ICON_W  = icon_pkg::ICON_W,
    parameter int ICON_H  = icon_pkg::ICON_H,
    parameter int Y_SCALE = icon_pkg::Y_SCALE,
    parameter int X_SHIFT = icon_pkg::X_SHIFT,
    parameter int ROM_AW  = icon_pkg::ROM_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              loc_valid,
    input  logic [7:0]        LocX,
    input  logic [7:0]        LocY,
    input  logic [7:0]        BotInfo,
    input  logic              icon_en,
    input  logic              pix_tick,
    input  logic [9:0]        pixel_row,
    input  logic [9:0]        pixel_column,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [1:0]        rom_data,
    output logic [1:0]        icon,
    output logic              icon_valid,
    output logic              busy
);
    import icon_pkg::*;

    localparam int OW = 11;
    localparam int RB = $clog2(ICON_H);
    localparam int CB = $clog2(ICON_W);

    logic unused_info;
    assign unused_info = ^BotInfo[7:3];

    state_e            state_q, state_d;
    logic              pend_q, pend_d;
    logic [7:0]        sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [7:0]        ac_x_q, ac_x_d, ac_y_q, ac_y_d;
    orient_e           sh_o_q, sh_o_d, ac_o_q, ac_o_d;
    logic              activate;
    logic [OW-1:0]     oy, ox, row_w, col_w, dr, dc;
    logic              hit;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              hit1_q, tick1_q, hit2_q, tick2_q, icon_valid_q;
    logic [1:0]        icon_q, icon_d;

    assign activate = frame_start & (pend_q | loc_valid);

    // A same-clock update bypasses the shadow so it is never left pending.
    always_comb begin
        sh_x_d = sh_x_q;
        sh_y_d = sh_y_q;
        sh_o_d = sh_o_q;
        pend_d = pend_q;
        ac_x_d = ac_x_q;
        ac_y_d = ac_y_q;
        ac_o_d = ac_o_q;
        if (loc_valid) begin
            sh_x_d = LocX;
            sh_y_d = LocY;
            sh_o_d = orient_e'(BotInfo[2:0]);
            pend_d = 1'b1;
        end
        if (frame_start) begin
            if (loc_valid) begin
                ac_x_d = LocX;
                ac_y_d = LocY;
                ac_o_d = orient_e'(BotInfo[2:0]);
                pend_d = 1'b0;
            end else if (pend_q) begin
                ac_x_d = sh_x_q;
                ac_y_d = sh_y_q;
                ac_o_d = sh_o_q;
                pend_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (activate) state_d = ST_SHOW;
                      else if (loc_valid) state_d = ST_ARMED;
            ST_ARMED: if (activate) state_d = ST_SHOW;
            ST_SHOW:  state_d = ST_SHOW;
            default:  state_d = ST_IDLE;
        endcase
        if (frame_start && !icon_en) begin
            state_d = ST_IDLE;
        end
    end

    // Offsets are unsigned 11-bit; a pixel left of/above the origin fails the >= test.
    always_comb begin
        oy         = OW'(ac_y_q) * OW'(Y_SCALE);
        ox         = OW'(ac_x_q) << X_SHIFT;
        row_w      = OW'(pixel_row);
        col_w      = OW'(pixel_column);
        dr         = row_w - oy;
        dc         = col_w - ox;
        hit        = pix_tick && (row_w >= oy) && (dr < OW'(ICON_H))
                              && (col_w >= ox) && (dc < OW'(ICON_W));
        rom_addr_d = hit ? {ac_o_q, dr[RB-1:0], dc[CB-1:0]} : rom_addr_q;
        icon_d     = (hit2_q && (state_q == ST_SHOW) && icon_en) ? rom_data : 2'b00;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pend_q       <= 1'b0;
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_o_q       <= OR_N;
            ac_x_q       <= '0;
            ac_y_q       <= '0;
            ac_o_q       <= OR_N;
            rom_addr_q   <= '0;
            hit1_q       <= 1'b0;
            tick1_q      <= 1'b0;
            hit2_q       <= 1'b0;
            tick2_q      <= 1'b0;
            icon_q       <= 2'b00;
            icon_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            sh_o_q       <= sh_o_d;
            ac_x_q       <= ac_x_d;
            ac_y_q       <= ac_y_d;
            ac_o_q       <= ac_o_d;
            rom_addr_q   <= rom_addr_d;
            hit1_q       <= hit;
            tick1_q      <= pix_tick;
            hit2_q       <= hit1_q;
            tick2_q      <= tick1_q;
            icon_q       <= icon_d;
            icon_valid_q <= tick2_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign icon       = icon_q;
    assign icon_valid = icon_valid_q;
    assign busy       = (state_q == ST_SHOW);

endmodule
`default_nettype wire

// File: tb/tb_icon_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icon_fetch_ctrl : directed bench for icon_fetch_ctrl with the     |
// |                      sprite ROM in the loop.  Rev 1.0                |
// +----------------------------------------------------------------------+
module tb_icon_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        loc_valid = 1'b0;
    logic [7:0]  LocX = '0;
    logic [7:0]  LocY = '0;
    logic [7:0]  BotInfo = '0;
    logic        icon_en = 1'b1;
    logic        pix_tick = 1'b0;
    logic [9:0]  pixel_row = '0;
    logic [9:0]  pixel_column = '0;
    logic [10:0] rom_addr;
    logic [1:0]  rom_data;
    logic [1:0]  icon;
    logic        icon_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          m_ox = 0, m_oy = 0, m_or = 0;
    bit          m_show = 0, m_en = 1;
    logic [10:0] m_addr = '0;
    logic [1:0]  h_icon [3];
    logic        h_valid [3];

    always #5 clock = ~clock;

    icon_fetch_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .loc_valid    (loc_valid),
        .LocX         (LocX),
        .LocY         (LocY),
        .BotInfo      (BotInfo),
        .icon_en      (icon_en),
        .pix_tick     (pix_tick),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .icon         (icon),
        .icon_valid   (icon_valid),
        .busy         (busy)
    );

    icon_sprite_rom u_rom (
        .clock (clock),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    function automatic logic [1:0] rom_model(input int a);
        return 2'((a ^ (a >> 2) ^ (a >> 4) ^ (a >> 6) ^ (a >> 8) ^ (a >> 10)) & 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            h_icon[i]  = 2'b00;
            h_valid[i] = 1'b0;
        end
    endtask

    // One clock: present a pixel, then check the result of the pixel from 3 clocks ago.
    task automatic step(input bit tick, input int row, input int col);
        bit         hit;
        logic [1:0] e;
        pix_tick     = tick;
        pixel_row    = 10'(row);
        pixel_column = 10'(col);
        hit = tick && row >= m_oy && row < m_oy + 16 && col >= m_ox && col < m_ox + 16;
        if (hit) m_addr = 11'(m_or * 256 + (row - m_oy) * 16 + (col - m_ox));
        e = (hit && m_show && m_en) ? rom_model(int'(m_addr)) : 2'b00;
        @(negedge clock);
        h_icon[2]  = h_icon[1];
        h_icon[1]  = h_icon[0];
        h_icon[0]  = e;
        h_valid[2] = h_valid[1];
        h_valid[1] = h_valid[0];
        h_valid[0] = tick;
        chk("icon", 32'(icon), 32'(h_icon[2]));
        chk("icon_valid", 32'(icon_valid), 32'(h_valid[2]));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("busy", 32'(busy), 32'(m_show));
        pix_tick = 1'b0;
    endtask

    task automatic flush();
        repeat (3) step(0, 0, 0);
    endtask

    task automatic ctl(input bit lv, input bit fs, input int x, input int y, input int info);
        loc_valid   = lv;
        frame_start = fs;
        LocX        = 8'(x);
        LocY        = 8'(y);
        BotInfo     = 8'(info);
        step(0, 0, 0);
        loc_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic scan(input int row, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) step(1, row, c);
    endtask

    initial begin
        clear_hist();
        repeat (2) @(negedge clock);
        chk("rst_icon", 32'(icon), 32'h0);
        chk("rst_valid", 32'(icon_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        reset = 1'b1;

        // Load E at (10,20): origin col 80, row 120
        ctl(1, 0, 10, 20, 8'h02);
        m_ox = 80; m_oy = 120; m_or = 2; m_show = 1;
        ctl(0, 1, 0, 0, 0);
        step(1, 120, 80);
        chk("addr_first", 32'(rom_addr), 32'h200);
        scan(120, 81, 95);
        chk("addr_last", 32'(rom_addr), 32'h20F);
        flush();

        // Corner pixel and just-outside neighbours
        step(1, 135, 95);
        chk("addr_corner", 32'(rom_addr), 32'h2FF);
        step(1, 136, 95);
        step(1, 120, 96);
        flush();

        // Two updates mid-frame: last wins, applied only at frame_start
        ctl(1, 0, 10, 20, 8'h04);
        ctl(1, 0, 10, 20, 8'h07);
        scan(121, 80, 83);
        chk("addr_keep_e", 32'(rom_addr), 32'h213);
        flush();
        m_or = 7;
        ctl(0, 1, 0, 0, 0);
        step(1, 121, 80);
        chk("addr_nw", 32'(rom_addr), 32'h710);
        scan(121, 81, 83);
        flush();

        // Tick pattern 1,0,1,1
        step(1, 122, 84);
        step(0, 122, 85);
        step(1, 122, 85);
        step(1, 122, 86);
        flush();

        // Master enable blanks at once, and drops to IDLE at frame_start
        icon_en = 1'b0; m_en = 0;
        scan(122, 80, 83);
        flush();
        m_show = 0;
        ctl(0, 1, 0, 0, 0);
        icon_en = 1'b1; m_en = 1;
        scan(122, 80, 81);
        flush();
        ctl(1, 0, 10, 20, 8'h02);
        m_or = 2; m_show = 1;
        ctl(0, 1, 0, 0, 0);
        scan(123, 80, 82);
        flush();

        // Same-clock update far off-screen: oy = 1530, no wrapped hit at row 506
        m_ox = 0; m_oy = 1530; m_or = 0;
        ctl(1, 1, 0, 255, 8'h00);
        scan(0, 0, 15);
        scan(479, 0, 15);
        scan(506, 0, 15);
        flush();

        // Reset in the middle of a scan in SHOW
        m_ox = 80; m_oy = 120; m_or = 2;
        ctl(1, 1, 10, 20, 8'h02);
        scan(120, 80, 83);
        reset = 1'b0;
        #1;
        chk("mid_rst_icon", 32'(icon), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clock);
        chk("mid_rst_valid", 32'(icon_valid), 32'h0);
        chk("mid_rst_addr", 32'(rom_addr), 32'h0);
        reset = 1'b1;
        clear_hist();
        m_show = 0; m_ox = 0; m_oy = 0; m_or = 0; m_addr = '0;
        scan(120, 80, 81);
        scan(0, 0, 3);
        flush();
        ctl(1, 0, 10, 20, 8'h02);
        scan(120, 80, 80);
        flush();
        m_ox = 80; m_oy = 120; m_or = 2; m_show = 1;
        ctl(0, 1, 0, 0, 0);
        scan(120, 80, 83);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
